// File: rtl/conv1d_sequencer.sv
// Job sequencer for a conv1d engine: walks output positions, polls the engine,
// and queues each accumulator result into a small result FIFO.
module conv1d_sequencer #(
  parameter int POLL_LIMIT = 255,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [2:0]  job_base_x,
  input  logic [15:0] job_num_pos,
  input  logic        job_refill,
  input  logic        abort,
  output logic [6:0]  eng_cmd,
  output logic [31:0] eng_value,
  input  logic [31:0] eng_ret,
  output logic        col_req,
  input  logic        col_ack,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_last,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(POLL_LIMIT + 1);

  localparam logic [6:0] CMD_NOP   = 7'd0;
  localparam logic [6:0] CMD_START = 7'd6;
  localparam logic [6:0] CMD_READ  = 7'd7;
  localparam logic [6:0] CMD_SET_X = 7'd8;
  localparam logic [6:0] CMD_POLL  = 7'd9;

  typedef enum logic [3:0] {
    IDLE, SET_X, START, POLL, CHECK, READ, CAPT, REFILL, DONE
  } state_t;

  state_t        state;
  logic [2:0]    base_x;
  logic [15:0]   num_pos;
  logic [15:0]   p;
  logic          refill;
  logic [PW-1:0] poll_cnt;
  logic [2:0]    col_cur;
  logic [2:0]    col_next;

  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic          fifo_last [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  logic          last_pos;

  assign col_cur   = base_x + p[2:0];
  assign col_next  = base_x + p[2:0] + 3'd1;
  assign last_pos  = (p == num_pos - 16'd1);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign push      = (state == CAPT) && !abort && !full;
  assign pop       = res_valid && res_ready;
  assign res_valid = (count != '0);
  assign res_data  = res_valid ? fifo_data[rd_ptr] : '0;
  assign res_last  = res_valid ? fifo_last[rd_ptr] : 1'b0;
  assign job_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Outputs are registered alongside the state, so each transition also sets
  // the command the engine sees in the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      eng_cmd     <= CMD_NOP;
      eng_value   <= '0;
      col_req     <= 1'b0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
      base_x      <= '0;
      num_pos     <= '0;
      refill      <= 1'b0;
      p           <= '0;
      poll_cnt    <= '0;
    end else begin
      eng_cmd   <= CMD_NOP;
      eng_value <= '0;
      col_req   <= 1'b0;
      done      <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (job_valid) begin
            base_x      <= job_base_x;
            num_pos     <= job_num_pos;
            refill      <= job_refill;
            p           <= '0;
            poll_cnt    <= '0;
            err_timeout <= 1'b0;
            if (job_num_pos == 16'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SET_X;
              eng_cmd   <= CMD_SET_X;
              eng_value <= {29'd0, job_base_x};
            end
          end
          SET_X: begin
            state   <= START;
            eng_cmd <= CMD_START;
          end
          START: begin
            state   <= POLL;
            eng_cmd <= CMD_POLL;
          end
          POLL: state <= CHECK;
          CHECK: begin
            if (eng_ret[0]) begin
              state    <= READ;
              eng_cmd  <= CMD_READ;
              poll_cnt <= '0;
            end else if (poll_cnt == PW'(POLL_LIMIT - 1)) begin
              state       <= DONE;
              done        <= 1'b1;
              err_timeout <= 1'b1;
            end else begin
              state    <= POLL;
              eng_cmd  <= CMD_POLL;
              poll_cnt <= poll_cnt + PW'(1);
            end
          end
          READ: state <= CAPT;
          // A full FIFO holds us here; the engine keeps eng_ret stable under no-op.
          CAPT: if (!full) begin
            p <= p + 16'd1;
            if (last_pos) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (refill) begin
              state   <= REFILL;
              col_req <= 1'b1;
            end else begin
              state     <= SET_X;
              eng_cmd   <= CMD_SET_X;
              eng_value <= {29'd0, col_next};
            end
          end
          REFILL: begin
            if (col_ack) begin
              state     <= SET_X;
              eng_cmd   <= CMD_SET_X;
              eng_value <= {29'd0, col_cur};
            end else begin
              col_req <= 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Push is refused whenever the FIFO is full, even if a pop happens that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= eng_ret;
      fifo_last[wr_ptr] <= last_pos;
    end
  end

endmodule

// File: tb/tb_conv1d_sequencer.sv
// Scoreboard bench for conv1d_sequencer with a behavioural engine model.
module tb_conv1d_sequencer;

  localparam int POLL_LIMIT = 4;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [2:0]  job_base_x = '0;
  logic [15:0] job_num_pos = '0;
  logic        job_refill = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  eng_cmd;
  logic [31:0] eng_value;
  logic [31:0] eng_ret = '0;
  logic        col_req;
  logic        col_ack = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_data;
  logic        res_last;
  logic        busy;
  logic        done;
  logic        err_timeout;

  conv1d_sequencer #(.POLL_LIMIT(POLL_LIMIT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base_x(job_base_x), .job_num_pos(job_num_pos), .job_refill(job_refill),
    .abort(abort),
    .eng_cmd(eng_cmd), .eng_value(eng_value), .eng_ret(eng_ret),
    .col_req(col_req), .col_ack(col_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [2:0]  col_q [$];
  logic [31:0] ret_q [$];
  logic [32:0] exp_q [$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int cmd_cnt = 0;
  int cmd8_cnt = 0;
  int total_polls = 0;
  int eng_polls = 0;
  int need_polls = 1;
  int req_rises = 0;
  int req_cycles = 0;
  int req_run = 0;
  int last_cmd8_req = 0;
  logic prev_req = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Engine model and column handshake, evaluated away from the active edge.
  always @(negedge clk) begin
    if (col_req) begin
      if (!prev_req) req_rises++;
      req_cycles++;
      req_run++;
    end else begin
      req_run = 0;
    end
    prev_req = col_req;
    col_ack  = col_req && (req_run == 5);
    if (done) done_cnt++;
    if (eng_cmd != 7'd0) cmd_cnt++;
    case (eng_cmd)
      7'd8: begin
        cmd8_cnt++;
        last_cmd8_req = req_cycles;
        if (col_q.size() == 0) checkOutput("eng_value_extra", eng_value, 32'hFFFF_FFFF);
        else checkOutput("eng_value", eng_value, {29'd0, col_q.pop_front()});
      end
      7'd6: begin
        eng_polls = 0;
        eng_ret   = '0;
      end
      7'd9: begin
        eng_polls++;
        total_polls++;
        eng_ret = (eng_polls >= need_polls) ? 32'd1 : 32'd0;
      end
      7'd7: eng_ret = (ret_q.size() != 0) ? ret_q.pop_front() : 32'hBAD0_BAD0;
      default: ;
    endcase
  end

  // Result monitor: pops the scoreboard whenever the FIFO hands over a word.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("res_unexpected", res_data, 32'hFFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        checkOutput("res_data", res_data, e[31:0]);
        checkOutput("res_last", {31'd0, res_last}, {31'd0, e[32]});
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] base, input logic [15:0] num, input logic rf,
                               input int need, input logic [31:0] d0, input logic [31:0] dstep,
                               input int n_run);
    int nc;
    logic [2:0] c;
    logic [31:0] d;
    need_polls = need;
    for (int i = 0; i < n_run; i++) begin
      d = d0 + dstep * i;
      ret_q.push_back(d);
      exp_q.push_back({(i == int'(num) - 1), d});
    end
    nc = (n_run < int'(num)) ? n_run + 1 : n_run;
    for (int i = 0; i < nc; i++) begin
      c = base + 3'(i);
      col_q.push_back(c);
    end
    checkOutput("job_ready", {31'd0, job_ready}, 32'd1);
    job_base_x  = base;
    job_num_pos = num;
    job_refill  = rf;
    job_valid   = 1'b1;
    @(posedge clk); #1;
    job_valid   = 1'b0;
  endtask

  task automatic waitDone(input int max_cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checkOutput("done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_eng_cmd", {25'd0, eng_cmd}, 32'd0);
    checkOutput("rst_eng_value", eng_value, 32'd0);
    checkOutput("rst_res_valid", {31'd0, res_valid}, 32'd0);
    checkOutput("rst_res_data", res_data, 32'd0);
    checkOutput("rst_res_last", {31'd0, res_last}, 32'd0);
    checkOutput("rst_col_req", {31'd0, col_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
    checkOutput("rst_job_ready", {31'd0, job_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc0, c0, c8, tp0, rc0;
    logic seen;

    repeat (2) @(posedge clk);
    #1;
    checkResetValues();
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Three positions wrapping the ring column 6,7,0; engine finishes on 2nd poll.
    $display("[TB] basic job base_x=6 num_pos=3");
    dc0 = done_cnt;
    applyStimulus(3'd6, 16'd3, 1'b0, 2, 32'h11, 32'h11, 3);
    waitDone(100);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("basic_done_pulses", done_cnt - dc0, 32'd1);
    checkOutput("basic_err_timeout", {31'd0, err_timeout}, 32'd0);
    checkOutput("basic_sb_empty", exp_q.size(), 32'd0);

    // Empty job: done straight after acceptance with no engine traffic.
    $display("[TB] empty job");
    c0 = cmd_cnt;
    applyStimulus(3'd2, 16'd0, 1'b0, 1, 32'd0, 32'd0, 0);
    @(negedge clk);
    checkOutput("empty_done", {31'd0, done}, 32'd1);
    checkOutput("empty_eng_cmd", {25'd0, eng_cmd}, 32'd0);
    @(negedge clk);
    checkOutput("empty_done_cleared", {31'd0, done}, 32'd0);
    checkOutput("empty_cmd_count", cmd_cnt - c0, 32'd0);
    checkOutput("empty_res_valid", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;

    // Refill between two positions with the host acking after 5 cycles.
    $display("[TB] refill job");
    rc0 = req_rises;
    req_cycles = 0;
    c8 = cmd8_cnt;
    applyStimulus(3'd3, 16'd2, 1'b1, 1, 32'h200, 32'h1, 2);
    waitDone(100);
    checkOutput("refill_req_rises", req_rises - rc0, 32'd1);
    checkOutput("refill_req_cycles", req_cycles, 32'd5);
    checkOutput("refill_cmd8_after_ack", last_cmd8_req, 32'd5);
    checkOutput("refill_cmd8_count", cmd8_cnt - c8, 32'd2);

    // Backpressure: FIFO fills after 4 results, 5th position stalls in CAPT.
    $display("[TB] backpressure job");
    res_ready = 1'b0;
    c8 = cmd8_cnt;
    dc0 = done_cnt;
    applyStimulus(3'd0, 16'd6, 1'b0, 1, 32'h101, 32'h1, 6);
    repeat (60) @(posedge clk);
    @(negedge clk);
    checkOutput("stall_cmd8_count", cmd8_cnt - c8, 32'd5);
    checkOutput("stall_busy", {31'd0, busy}, 32'd1);
    checkOutput("stall_eng_cmd", {25'd0, eng_cmd}, 32'd0);
    checkOutput("stall_head", res_data, 32'h101);
    checkOutput("stall_no_done", done_cnt - dc0, 32'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    waitDone(200);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("stall_sb_empty", exp_q.size(), 32'd0);
    checkOutput("stall_res_valid", {31'd0, res_valid}, 32'd0);

    // Engine never reports ready: timeout after POLL_LIMIT checks.
    $display("[TB] timeout job");
    tp0 = total_polls;
    dc0 = done_cnt;
    applyStimulus(3'd5, 16'd1, 1'b0, 1000, 32'd0, 32'd0, 0);
    waitDone(100);
    checkOutput("timeout_polls", total_polls - tp0, 32'd4);
    checkOutput("timeout_err", {31'd0, err_timeout}, 32'd1);
    checkOutput("timeout_done_pulses", done_cnt - dc0, 32'd1);
    checkOutput("timeout_res_valid", {31'd0, res_valid}, 32'd0);
    applyStimulus(3'd0, 16'd0, 1'b0, 1, 32'd0, 32'd0, 0);
    @(negedge clk);
    checkOutput("timeout_err_cleared", {31'd0, err_timeout}, 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Abort during POLL, then reset during START of the following job.
    $display("[TB] abort and reset");
    dc0 = done_cnt;
    applyStimulus(3'd1, 16'd2, 1'b0, 1000, 32'd0, 32'd0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (eng_cmd == 7'd9) seen = 1'b1;
    end
    checkOutput("abort_poll_seen", {31'd0, seen}, 32'd1);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_eng_cmd", {25'd0, eng_cmd}, 32'd0);
    checkOutput("abort_job_ready", {31'd0, job_ready}, 32'd1);
    @(posedge clk); #1;
    applyStimulus(3'd4, 16'd3, 1'b0, 1000, 32'd0, 32'd0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (eng_cmd == 7'd6) seen = 1'b1;
    end
    checkOutput("reset_start_seen", {31'd0, seen}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues();
    checkOutput("abort_reset_no_done", done_cnt - dc0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("post_reset_eng_cmd", {25'd0, eng_cmd}, 32'd0);
    checkOutput("col_queue_empty", col_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv1d_sequencer.md
CONV1D_SEQUENCER -- requirements
Module: conv1d_sequencer

Interface
REQ-001 Parameter POLL_LIMIT, default 255, max CHECK visits per position before timeout.
REQ-002 Parameter FIFO_DEPTH, default 4, result FIFO entries (power of two).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 job_valid  input  1  job request.
REQ-006 job_ready  output  1  high only in IDLE.
REQ-007 job_base_x  input  3  ring-buffer start column for position 0.
REQ-008 job_num_pos  input  16  output positions to compute.
REQ-009 job_refill  input  1  request host column refill between positions.
REQ-010 abort  input  1  synchronous job cancel.
REQ-011 eng_cmd  output  7  command to conv1d engine.
REQ-012 eng_value  output  32  value operand to engine.
REQ-013 eng_ret  input  32  engine return register.
REQ-014 col_req  output  1  host must write next input column.
REQ-015 col_ack  input  1  column written.
REQ-016 res_valid / res_ready  output / input  1  result FIFO handshake.
REQ-017 res_data  output  32  accumulator value.
REQ-018 res_last  output  1  marks last position of job.
REQ-019 busy  output  1  high in any state except IDLE.
REQ-020 done  output  1  one-cycle pulse at job completion.
REQ-021 err_timeout  output  1  sticky; cleared by next accepted job.

Function
REQ-022 States: IDLE, SET_X, START, POLL, CHECK, READ, CAPT, REFILL, DONE.
REQ-023 eng_cmd SHALL be 0 (no-op) in every state not listed below; eng_value 0 unless stated.
REQ-024 IDLE: job_valid&&job_ready latches base_x, num_pos, refill, clears p counter and err_timeout; num_pos==0 -> DONE, no engine command issued; else -> SET_X.
REQ-025 SET_X: eng_cmd=8, eng_value=(base_x+p) mod 8, zero-extended; -> START next cycle.
REQ-026 START: eng_cmd=6; -> POLL.
REQ-027 POLL: eng_cmd=9; -> CHECK.
REQ-028 CHECK: samples eng_ret[0]; 1 -> READ; 0 -> POLL, poll counter +1; counter reaching POLL_LIMIT -> err_timeout=1, -> DONE.
REQ-029 READ: eng_cmd=7; -> CAPT.
REQ-030 CAPT: pushes eng_ret into FIFO with res_last=(p==num_pos-1) when not full; full -> stays in CAPT (eng_ret stable under cmd 0); after push p+1; p==num_pos -> DONE; else refill -> REFILL; else -> SET_X.
REQ-031 REFILL: col_req=1 until col_ack sampled high, then -> SET_X; col_ack outside REFILL ignored.
REQ-032 DONE: done=1 for one cycle; -> IDLE.
REQ-033 Per-position engine latency (no stalls): SET_X..CAPT = 4 + 2*k cycles, k = CHECK visits.
REQ-034 abort in any non-IDLE state -> IDLE next cycle, eng_cmd=0, no done pulse; FIFO contents retained; abort in IDLE ignored.
REQ-035 FIFO: simultaneous push and pop when full SHALL NOT be accepted for push (push waits one cycle); pop when empty impossible (res_valid low).
REQ-036 p counter 16-bit; ring column wraps modulo 8 (base_x=6, p=3 -> 1).

Reset
REQ-037 rst_n low asynchronously forces IDLE, eng_cmd=0, eng_value=0, FIFO empty, res_valid=0, res_data=0, res_last=0, col_req=0, busy=0, done=0, err_timeout=0, p=0.
REQ-038 Reset mid-job discards job and FIFO; engine is not commanded further.

Verification
REQ-039 base_x=6, num_pos=3, refill=0, engine model done after 2 polls, ret 0x11,0x22,0x33 -> eng_value sequence 6,7,0 on cmd 8; FIFO yields 0x11,0x22,0x33, res_last only on 0x33; single done pulse.
REQ-040 num_pos=0 -> done one cycle after acceptance, eng_cmd stays 0, FIFO empty.
REQ-041 refill=1, num_pos=2, col_ack delayed 5 cycles -> col_req high exactly once, 5 cycles, between positions; second cmd 8 follows ack.
REQ-042 res_ready=0, num_pos=6, FIFO_DEPTH=4 -> sequencer stalls in CAPT after 4 pushes; releasing res_ready completes all 6 in order.
REQ-043 engine never finishes, POLL_LIMIT=4 -> err_timeout=1 after 4 CHECKs, done pulses, next job clears err_timeout.
REQ-044 abort during POLL, then rst_n pulse during START of new job -> IDLE each time, no done, all outputs at reset values.
